// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the unified-memory port
//                arbiter: owner encoding, default widths and starve counter
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Which requester owns an outstanding read.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int c_def_addr_w = 32;
    localparam int c_def_data_w = 32;
    localparam int c_starve_w   = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_owner_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : arb_owner_fifo
//  Description : In-order FIFO of read owners (OWN_IF / OWN_D), one entry per
//                outstanding memory read. Push and pop in the same cycle are
//                legal when full; the count is then unchanged.
//  Ports       : clk, rst_n (async active-low)
//                i_push/i_push_own  - enqueue an owner
//                i_pop              - dequeue the head (ignored when empty)
//                o_full/o_empty     - status
//                o_count            - number of entries held
//                o_head             - owner at the head
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  owner_e                   i_push_own,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output owner_e                   o_head
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

    owner_e               r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full   = (r_count == c_depth);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rd_ptr];

    // A pop frees the slot the push would need, so full + pop still accepts.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= OWN_IF;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_own;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : arb_owner_fifo
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares a single-port memory between the instruction-fetch
//                port and the load/store port. Data wins over fetch unless
//                fetch has been denied STARVE_LIMIT consecutive cycles.
//                Outstanding reads are tracked in order so each response is
//                steered to its requester with no added latency.
//  Ports       : clk, rst_n (async active-low)
//                i_*  - fetch request/grant/response
//                d_*  - load/store request/grant/response
//                m_*  - memory macro interface
//                busy - at least one read outstanding
//                err  - sticky: response seen with nothing outstanding
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = c_def_addr_w,
    parameter int DATA_W       = c_def_data_w,
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [c_starve_w-1:0] c_starve_lim = c_starve_w'(STARVE_LIMIT);
    localparam logic [c_starve_w-1:0] c_starve_max = '1;

    logic [c_starve_w-1:0]        r_starve_cnt;
    logic                         r_err;

    logic                         w_force_if;
    logic                         w_sel_d;
    logic                         w_sel_valid;
    logic                         w_sel_read;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_accept;
    logic                         w_full;
    logic                         w_empty;
    logic [$clog2(MAX_OUTST):0]   w_count;
    owner_e                       w_head;
    owner_e                       w_push_own;

    // ---------------------------------------------------------------- select
    assign w_force_if  = i_req & (r_starve_cnt >= c_starve_lim);
    assign w_sel_d     = ~w_force_if & d_req;
    assign w_sel_valid = w_sel_d ? d_req : i_req;
    assign w_sel_read  = w_sel_d ? ~d_we : 1'b1;
    assign w_pop       = m_rvalid & ~w_empty;

    // A read cannot issue into a full FIFO unless a response frees a slot
    // in the same cycle. Outputs are held low throughout reset.
    assign m_req    = rst_n & w_sel_valid & ~(w_sel_read & w_full & ~w_pop);
    assign m_we     = w_sel_d & d_we;
    assign m_addr   = w_sel_d ? d_addr : i_addr;
    assign m_wdata  = d_wdata;

    assign w_accept = m_req & m_ready;
    assign i_gnt    = w_accept & ~w_sel_d;
    assign d_gnt    = w_accept &  w_sel_d;

    assign w_push     = w_accept & w_sel_read;
    assign w_push_own = w_sel_d ? OWN_D : OWN_IF;

    // -------------------------------------------------------------- response
    assign i_rvalid = rst_n & w_pop & (w_head == OWN_IF);
    assign d_rvalid = rst_n & w_pop & (w_head == OWN_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    assign busy = (w_count != '0);
    assign err  = r_err;

    // ----------------------------------------------------- starve counter/err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            if (i_req & ~i_gnt) begin
                if (r_starve_cnt != c_starve_max) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
            if (m_rvalid & w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ owner FIFO
    arb_owner_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_own (w_push_own),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_head     (w_head)
    );

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_OUTST    (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .busy     (busy),
        .err      (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here and
    // combinational outputs are sampled #1 later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    initial begin
        idle_inputs();
        m_ready = 1'b1;
        rst_n   = 1'b0;

        // ---------------- reset state, requests held during reset
        i_req = 1'b1;
        d_req = 1'b1;
        #1;
        check("rst_m_req", m_req, 0);
        check("rst_gnts", {i_gnt, d_gnt}, 0);
        check("rst_busy_err", {busy, err}, 0);
        tick();
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- single fetch and its response
        i_req = 1'b1; i_addr = 32'h0;
        #1;
        check("f1_i_gnt", i_gnt, 1);
        check("f1_m_addr_we", {m_addr, m_we}, {32'h0, 1'b0});
        tick();
        i_req = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h0050_0093;
        #1;
        check("f1_rvalids", {i_rvalid, d_rvalid}, 2'b10);
        check("f1_i_rdata", i_rdata, 32'h0050_0093);
        tick();
        m_rvalid = 1'b0;
        #1;
        check("f1_busy_done", busy, 0);

        // ---------------- contention: data wins until fetch starves
        i_req = 1'b1; i_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        for (int c = 0; c < 5; c++) begin
            m_rvalid = (c != 0);   // retire the previous read each cycle
            m_rdata  = 32'(c);
            #1;
            check($sformatf("arb_c%0d_gnts", c), {i_gnt, d_gnt},
                  (c == 3) ? 2'b10 : 2'b01);
            if (c == 4) begin
                check("arb_starve_clr", dut.r_starve_cnt, 0);
                check("arb_c4_i_rvalid", i_rvalid, 1);
            end
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        m_rvalid = 1'b1;
        tick();
        m_rvalid = 1'b0;
        #1;
        check("arb_drained", busy, 0);

        // ---------------- in-order routing D, IF, D
        d_req = 1'b1; d_addr = 32'h100;
        tick();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h8;
        tick();
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h104;
        tick();
        d_req = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hA;
        #1;
        check("ord_A", {i_rvalid, d_rvalid, d_rdata}, {2'b01, 32'hA});
        tick();
        m_rdata = 32'hB;
        #1;
        check("ord_B", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 32'hB});
        tick();
        m_rdata = 32'hC;
        #1;
        check("ord_C", {i_rvalid, d_rvalid, d_rdata, busy}, {2'b01, 32'hC, 1'b1});
        tick();
        m_rvalid = 1'b0;
        #1;
        check("ord_busy_done", busy, 0);

        // ---------------- store: granted, nothing tracked
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
        #1;
        check("st_gnt_we", {d_gnt, m_we}, 2'b11);
        check("st_addr_data", {m_addr, m_wdata}, {32'h80, 32'hDEAD_BEEF});
        tick();
        d_req = 1'b0; d_we = 1'b0;
        #1;
        check("st_no_outst", {busy, dut.u_fifo.o_count}, 0);

        // ---------------- fill the FIFO, then pop+push while full
        d_req = 1'b1; d_addr = 32'h200;
        for (int k = 0; k < 4; k++) tick();
        #1;
        check("full_block", {m_req, d_gnt}, 2'b00);
        m_rvalid = 1'b1; m_rdata = 32'h55;
        #1;
        check("full_poppush", {m_req, d_gnt, d_rvalid}, 3'b111);
        tick();
        m_rvalid = 1'b0; d_req = 1'b0;
        #1;
        check("full_count4", dut.u_fifo.o_count, 4);
        m_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        m_rvalid = 1'b0;
        #1;
        check("full_drained", busy, 0);

        // ---------------- m_ready low: held, starve still counts
        m_ready = 1'b0; i_req = 1'b1; i_addr = 32'hC;
        #1;
        check("nrdy_hold", {m_req, i_gnt}, 2'b10);
        tick(); tick();
        check("nrdy_starve", dut.r_starve_cnt, 2);
        m_ready = 1'b1;
        #1;
        check("nrdy_gnt", i_gnt, 1);
        tick();
        i_req = 1'b0;
        m_rvalid = 1'b1;
        tick();
        m_rvalid = 1'b0;

        // ---------------- stray response sets sticky err
        m_rvalid = 1'b1; m_rdata = 32'h77;
        #1;
        check("err_drop", {i_rvalid, d_rvalid}, 0);
        tick();
        m_rvalid = 1'b0;
        tick(); tick();
        check("err_sticky", {err, busy}, 2'b10);

        // ---------------- reset with reads outstanding
        d_req = 1'b1; d_addr = 32'h300;
        tick(); tick();
        i_req = 1'b1;
        #1;
        check("rst2_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst2_state", {busy, err, i_gnt, d_gnt, m_req}, 0);
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (PC-addressed) and the load/store data port of the RV32 core.
- Arbitrates per cycle with data-over-fetch priority and a fetch anti-starvation counter.
- Tracks outstanding reads in an in-order owner FIFO and routes each read response back to its requester.
- Sits between the core (PC/imem side, LW/SW side) and the memory macro.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_OUTST, 4, maximum outstanding reads; power of 2, at least 2.
- STARVE_LIMIT, 3, consecutive denied fetch cycles before fetch is forced to win; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_ready  in  1  memory accepts request this cycle
- m_rvalid  in  1  read data returned, in issue order, at least 1 cycle after accept
- m_rdata  in  DATA_W  memory read data
- busy  out  1  at least one read outstanding
- err  out  1  sticky: m_rvalid seen with no outstanding read

Behaviour:
- Reset is asynchronous and active-low: rst_n (async, active-low), clock clk.
  - While rst_n = 0: owner FIFO empty, starve counter 0, err 0, busy 0.
  - While rst_n = 0: m_req, i_gnt, d_gnt, i_rvalid and d_rvalid are forced 0.
- Handshake:
  - A requester holds req and its address/data stable until it sees its gnt.
  - gnt is combinational, same cycle as the request.
  - A transfer is accepted when m_req & m_ready.
  - Exactly one of i_gnt/d_gnt may be high in a cycle; it equals accept for the selected requester.
- Selection (combinational):
  - fetch is forced when i_req & starve_cnt >= STARVE_LIMIT.
  - Otherwise data is selected when d_req; otherwise fetch is selected when i_req.
  - m_req = selected requester valid & !(selected is a read & FIFO full & !pop).
  - m_addr, m_we and m_wdata come from the selected requester; m_we is 0 for fetch.
- Starve counter (4 bits):
  - Increments, saturating at 15, when i_req & !i_gnt.
  - Clears on i_gnt or when !i_req.
- Owner FIFO:
  - Depth MAX_OUTST, 1-bit entries (OWN_IF / OWN_D).
  - Push on an accepted read; a store is not pushed and gets no response.
  - Pop on m_rvalid when non-empty.
  - Push and pop in the same cycle are allowed when full; count is unchanged.
  - Pointers wrap modulo MAX_OUTST.
  - busy = count != 0.
- Response routing:
  - i_rvalid = m_rvalid & nonempty & head == OWN_IF; d_rvalid = m_rvalid & nonempty & head == OWN_D.
  - i_rdata = d_rdata = m_rdata, unregistered.
  - Zero added latency on the response path; request path is combinational only.
- Error: m_rvalid with an empty FIFO sets err, which stays set until reset. The response is dropped and the FIFO is not popped.
- Reset mid-operation: outstanding reads are discarded. The memory macro shares rst_n, so it drops in-flight reads too.
- m_ready = 0: no grant, the request is held, and the starve counter still counts denied fetch cycles.

Decomposition:
- Shared package mem_arb_pkg holds:
  - owner encoding: OWN_IF = 1'b0, OWN_D = 1'b1.
  - default widths ADDR_W/DATA_W = 32.
  - starve counter width 4.
- One sub-module, arb_owner_fifo:
  - parameterised depth.
  - push/pop/full/empty/count/head.
  - simultaneous push+pop legal when full.

Test Plan:
- Reset, then i_req = 1, i_addr = 0x0, m_ready = 1 → i_gnt = 1 same cycle; m_rvalid next cycle with 0x00500093 → i_rvalid = 1, i_rdata = 0x00500093, d_rvalid = 0.
- i_req and d_req (load 0x40) both held with m_ready = 1 and STARVE_LIMIT = 3 → d_gnt cycles 0–2, i_gnt cycle 3, d_gnt cycle 4; starve counter 0 after cycle 3.
- Issue load (D), fetch (IF), load (D); memory returns 0xA, 0xB, 0xC in order → d_rvalid/0xA, i_rvalid/0xB, d_rvalid/0xC; busy drops after the third response.
- Store d_we = 1, d_addr = 0x80, d_wdata = 0xDEADBEEF → m_we = 1, d_gnt = 1, FIFO count unchanged, no rvalid generated.
- 4 reads accepted with no response → 5th read not granted (m_req = 0); a cycle with m_rvalid and a new read → both pop and push, grant issued, count stays 4.
- m_rvalid pulse with FIFO empty → err = 1 and stays 1 until rst_n low; rst_n asserted with 2 reads outstanding → busy = 0, gnts 0 immediately.
